// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the instruction-decode stage.
//   - opcode constants for the supported instruction classes
//   - bit positions of each field in the 10-bit control word
//   - ctrl_t: packed view of the control word, MSB first
package id_pkg;

  localparam int CTRL_W = 10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Bit positions inside the flat control word
  localparam int CB_REG_DST    = 9;
  localparam int CB_ALU_SRC    = 8;
  localparam int CB_MEM_TO_REG = 7;
  localparam int CB_REG_WRITE  = 6;
  localparam int CB_MEM_READ   = 5;
  localparam int CB_MEM_WRITE  = 4;
  localparam int CB_BRANCH     = 3;
  localparam int CB_ALU_OP_HI  = 2;
  localparam int CB_ALU_OP_LO  = 1;
  localparam int CB_JUMP       = 0;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// id_regfile: register file for the decode stage.
//   clk, rst_n      : clock, asynchronous active-low reset
//   raddr_a/raddr_b : combinational read addresses, rdata_a/rdata_b results
//   wen/waddr/wdata : synchronous write port
// Register 0 always reads 0 and ignores writes. A write to the address being
// read in the same cycle is forwarded to the read port (write-before-read).
// INIT_INDEX=1 makes reset load reg[i] = i, otherwise all registers reset to 0.
module id_regfile #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int INIT_INDEX = 0,
  localparam int RA_W      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] raddr_a,
  input  logic [RA_W-1:0] raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            wen,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Register storage: reset image, then write port (reg0 never written)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (INIT_INDEX != 0) ? XLEN'(i) : {XLEN{1'b0}};
      end
    end else if (wen && (waddr != {RA_W{1'b0}})) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read port A with zero register and write forwarding
  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (raddr_a == {RA_W{1'b0}}) begin
      rdata_a = {XLEN{1'b0}};
    end else if (wen && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_q[raddr_a];
    end
  end

  // Read port B with zero register and write forwarding
  always_comb begin
    rdata_b = regs_q[raddr_b];
    if (raddr_b == {RA_W{1'b0}}) begin
      rdata_b = {XLEN{1'b0}};
    end else if (wen && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_q[raddr_b];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS-style instruction-decode stage with handshakes.
//   if_id_*  : upstream valid/ready handshake, PC+4 and instruction word
//   flush    : drop the instruction in ID and the pending ID/EX contents
//   wb_*     : write-back port into the local register file
//   id_ex_*  : registered decode results with valid/ready handshake
//   illegal  : one-cycle pulse when an unknown opcode issues (as a NOP)
// A load in ID/EX whose destination matches rs or rt of the instruction in
// ID stalls the input for one cycle and issues a bubble.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int INIT_INDEX = 0,
  localparam int RA_W      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_id_valid,
  output logic              if_id_ready,
  input  logic [XLEN-1:0]   if_id_pc,
  input  logic [31:0]       if_id_instr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              id_ex_valid,
  input  logic              id_ex_ready,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [XLEN-1:0]   id_ex_rs_data,
  output logic [XLEN-1:0]   id_ex_rt_data,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [RA_W-1:0]   id_ex_dest,
  output logic              illegal
);

  logic [5:0]      op;
  logic [RA_W-1:0] rs, rt, rd;
  logic [XLEN-1:0] rs_data, rt_data;
  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  logic            hazard, out_free;

  logic            valid_d, valid_q;
  ctrl_t           ctrl_d, ctrl_q;
  logic [XLEN-1:0] pc_d, pc_q, rs_data_d, rs_data_q, rt_data_d, rt_data_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic [RA_W-1:0] dest_d, dest_q;
  logic            illegal_d, illegal_q;

  assign op = if_id_instr[31:26];
  assign rs = RA_W'(if_id_instr[25:21]);
  assign rt = RA_W'(if_id_instr[20:16]);
  assign rd = RA_W'(if_id_instr[15:11]);

  id_regfile #(
    .XLEN       (XLEN),
    .NREGS      (NREGS),
    .INIT_INDEX (INIT_INDEX)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .wen     (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // Opcode decode into the control word; unknown opcodes become a NOP
  always_comb begin
    dec_ctrl    = ctrl_t'({CTRL_W{1'b0}});
    dec_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
      end
      OP_ADDI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_J: begin
        dec_ctrl.jump = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Load-use detection compares rt even for non-R-type (conservative)
  assign hazard   = valid_q && ctrl_q.mem_read && (dest_q != {RA_W{1'b0}}) &&
                    ((dest_q == rs) || (dest_q == rt));
  assign out_free = !valid_q || id_ex_ready;
  // flush always consumes the ID slot
  assign if_id_ready = flush || (out_free && !hazard);

  // Next-state for the ID/EX register, in edge priority order
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    dest_d    = dest_q;
    illegal_d = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_t'({CTRL_W{1'b0}});
    end else if (!out_free) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_t'({CTRL_W{1'b0}});
    end else if (if_id_valid) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      pc_d      = if_id_pc;
      rs_data_d = rs_data;
      rt_data_d = rt_data;
      imm_d     = XLEN'($signed(if_id_instr[15:0]));
      dest_d    = dec_ctrl.reg_dst ? rd : rt;
      illegal_d = dec_illegal;
    end else begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_t'({CTRL_W{1'b0}});
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= ctrl_t'({CTRL_W{1'b0}});
      pc_q      <= {XLEN{1'b0}};
      rs_data_q <= {XLEN{1'b0}};
      rt_data_q <= {XLEN{1'b0}};
      imm_q     <= {XLEN{1'b0}};
      dest_q    <= {RA_W{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      dest_q    <= dest_d;
      illegal_q <= illegal_d;
    end
  end

  assign id_ex_valid   = valid_q;
  assign id_ex_ctrl    = ctrl_q;
  assign id_ex_pc      = pc_q;
  assign id_ex_rs_data = rs_data_q;
  assign id_ex_rt_data = rt_data_q;
  assign id_ex_imm     = imm_q;
  assign id_ex_dest    = dest_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed-vector bench for id_stage_pipe (INIT_INDEX=1).
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk;
  logic            rst_n;
  logic            if_id_valid;
  logic            if_id_ready;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            flush;
  logic            wb_en;
  logic [RA_W-1:0] wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            id_ex_valid;
  logic            id_ex_ready;
  logic [9:0]      id_ex_ctrl;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_rs_data;
  logic [XLEN-1:0] id_ex_rt_data;
  logic [XLEN-1:0] id_ex_imm;
  logic [RA_W-1:0] id_ex_dest;
  logic            illegal;

  int n_checks;
  int n_fail;

  id_stage_pipe #(
    .XLEN       (32),
    .NREGS      (32),
    .INIT_INDEX (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_id_valid   (if_id_valid),
    .if_id_ready   (if_id_ready),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .flush         (flush),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .id_ex_valid   (id_ex_valid),
    .id_ex_ready   (id_ex_ready),
    .id_ex_ctrl    (id_ex_ctrl),
    .id_ex_pc      (id_ex_pc),
    .id_ex_rs_data (id_ex_rs_data),
    .id_ex_rt_data (id_ex_rt_data),
    .id_ex_imm     (id_ex_imm),
    .id_ex_dest    (id_ex_dest),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD_8_4_6  = 32'h0086_4010;
  localparam logic [31:0] I_LW_5_1     = 32'h8C25_0000;
  localparam logic [31:0] I_ADD_7_5_2  = 32'h00A2_3820;
  localparam logic [31:0] I_ADD_0_0_0  = 32'h0000_0020;
  localparam logic [31:0] I_ADDI_9_M1  = 32'h2009_FFFF;
  localparam logic [31:0] I_ILLEGAL    = 32'hFC00_0000;

  localparam logic [9:0] C_RTYPE = 10'b1001000100;
  localparam logic [9:0] C_LW    = 10'b0111100000;
  localparam logic [9:0] C_SW    = 10'b0100010000;
  localparam logic [9:0] C_BEQ   = 10'b0000001010;
  localparam logic [9:0] C_ADDI  = 10'b0101000000;
  localparam logic [9:0] C_J     = 10'b0000000001;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    if_id_valid = v;
    if_id_pc    = pc;
    if_id_instr = instr;
  endtask

  logic [31:0] tbl_instr [4];
  logic [9:0]  tbl_ctrl  [4];

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 32'd0;
    id_ex_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0);

    #3;
    check_val("rst_valid", id_ex_valid, 1'b0);
    check_val("rst_ctrl", id_ex_ctrl, 10'd0);
    check_val("rst_pc", id_ex_pc, 32'd0);
    check_val("rst_illegal", illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic R-type with indexed reset image
    drive(1'b1, 32'd4, I_ADD_8_4_6);
    tick();
    check_val("add_valid", id_ex_valid, 1'b1);
    check_val("add_rs", id_ex_rs_data, 32'd4);
    check_val("add_rt", id_ex_rt_data, 32'd6);
    check_val("add_dest", id_ex_dest, 5'd8);
    check_val("add_ctrl", id_ex_ctrl, C_RTYPE);
    check_val("add_pc", id_ex_pc, 32'd4);
    check_val("add_imm", id_ex_imm, 32'h0000_4010);

    // load-use: lw r5 then add r7 = r5 + r2
    drive(1'b1, 32'd8, I_LW_5_1);
    tick();
    check_val("lw_ctrl", id_ex_ctrl, C_LW);
    check_val("lw_dest", id_ex_dest, 5'd5);
    check_val("lw_rs", id_ex_rs_data, 32'd1);
    drive(1'b1, 32'd12, I_ADD_7_5_2);
    #1;
    check_val("hz_ready0", if_id_ready, 1'b0);
    tick();
    check_val("bubble_valid", id_ex_valid, 1'b0);
    check_val("bubble_ctrl", id_ex_ctrl, 10'd0);
    check_val("hz_ready1", if_id_ready, 1'b1);
    tick();
    check_val("lu_valid", id_ex_valid, 1'b1);
    check_val("lu_dest", id_ex_dest, 5'd7);
    check_val("lu_pc", id_ex_pc, 32'd12);
    check_val("lu_rs", id_ex_rs_data, 32'd5);
    check_val("lu_rt", id_ex_rt_data, 32'd2);

    // write-back bypass on rs = 4
    wb_en   = 1'b1;
    wb_addr = 5'd4;
    wb_data = 32'hDEAD_BEEF;
    drive(1'b1, 32'd16, I_ADD_8_4_6);
    tick();
    check_val("byp_rs", id_ex_rs_data, 32'hDEAD_BEEF);
    check_val("byp_rt", id_ex_rt_data, 32'd6);
    wb_addr = 5'd0;
    wb_data = 32'h0000_0055;
    drive(1'b1, 32'd20, I_ADD_0_0_0);
    tick();
    check_val("r0_rs", id_ex_rs_data, 32'd0);
    check_val("r0_rt", id_ex_rt_data, 32'd0);
    wb_en = 1'b0;

    // stall with output backpressure; reg4 keeps the written value
    drive(1'b1, 32'h20, I_ADD_8_4_6);
    tick();
    check_val("st_rs", id_ex_rs_data, 32'hDEAD_BEEF);
    id_ex_ready = 1'b0;
    drive(1'b1, 32'h24, I_ADDI_9_M1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("st_ready", if_id_ready, 1'b0);
      tick();
      check_val("st_valid", id_ex_valid, 1'b1);
      check_val("st_pc", id_ex_pc, 32'h20);
      check_val("st_dest", id_ex_dest, 5'd8);
      check_val("st_ctrl", id_ex_ctrl, C_RTYPE);
      check_val("st_hold_rs", id_ex_rs_data, 32'hDEAD_BEEF);
    end
    id_ex_ready = 1'b1;
    tick();
    check_val("addi_pc", id_ex_pc, 32'h24);
    check_val("addi_ctrl", id_ex_ctrl, C_ADDI);
    check_val("addi_imm", id_ex_imm, 32'hFFFF_FFFF);
    check_val("addi_dest", id_ex_dest, 5'd9);

    // flush with valid output and valid ID instruction
    drive(1'b1, 32'h28, I_ADD_8_4_6);
    flush = 1'b1;
    #1;
    check_val("fl_ready", if_id_ready, 1'b1);
    tick();
    flush = 1'b0;
    check_val("fl_valid", id_ex_valid, 1'b0);
    check_val("fl_ctrl", id_ex_ctrl, 10'd0);
    drive(1'b0, 32'h2C, I_ADD_8_4_6);
    tick();
    check_val("fl_gone", id_ex_valid, 1'b0);

    // illegal opcode pulses once and issues as NOP
    drive(1'b1, 32'h30, I_ILLEGAL);
    tick();
    check_val("ill_flag", illegal, 1'b1);
    check_val("ill_valid", id_ex_valid, 1'b1);
    check_val("ill_ctrl", id_ex_ctrl, 10'd0);
    drive(1'b0, 32'h34, 32'd0);
    tick();
    check_val("ill_clear", illegal, 1'b0);
    check_val("idle_valid", id_ex_valid, 1'b0);

    // remaining decode table rows
    tbl_instr[0] = 32'hAC00_0000; tbl_ctrl[0] = C_SW;
    tbl_instr[1] = 32'h1000_0000; tbl_ctrl[1] = C_BEQ;
    tbl_instr[2] = 32'h0800_0000; tbl_ctrl[2] = C_J;
    tbl_instr[3] = I_LW_5_1;      tbl_ctrl[3] = C_LW;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h40 + 32'(k), tbl_instr[k]);
      tick();
      check_val("tbl_ctrl", id_ex_ctrl, tbl_ctrl[k]);
      check_val("tbl_pc", id_ex_pc, 32'h40 + 32'(k));
    end

    // asynchronous reset mid-stream
    drive(1'b1, 32'h50, I_ADD_8_4_6);
    tick();
    check_val("pre_rst_valid", id_ex_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", id_ex_valid, 1'b0);
    check_val("arst_ctrl", id_ex_ctrl, 10'd0);
    check_val("arst_pc", id_ex_pc, 32'd0);
    check_val("arst_rs", id_ex_rs_data, 32'd0);
    check_val("arst_dest", id_ex_dest, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_rs", id_ex_rs_data, 32'd4);
    check_val("post_rst_pc", id_ex_pc, 32'h50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
